// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Purpose: runs 8-bit NOT/NOR/SHL/SHR/ADD/SUB commands as two or three passes
//          through an external combinational 4-bit ALU slice.
// Ports:   cmd_*  command handshake (cmd_ready high only in IDLE)
//          rsp_*  response handshake (held in RESP until rsp_ready)
//          alu_*  registered drive to the ALU slice; alu_s/alu_carry sampled back
// Latency: LO E0->E1, HI E1->E2, optional FIX E2->E3; response right after.
//          Illegal opcodes respond the cycle after acceptance with no ALU pass.
module alu_nibble_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_sel1,
  output logic       alu_sel0,
  output logic       alu_mode_shift,
  output logic       alu_mode_adder,
  input  logic [3:0] alu_s,
  input  logic       alu_carry
);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_NOR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // {sel1, sel0, mode_shift, mode_adder}; unused mode bits stay 0
  function automatic logic [3:0] op_ctrl(input logic [2:0] op);
    case (op)
      OP_NOT:  op_ctrl = 4'b0000;
      OP_NOR:  op_ctrl = 4'b0100;
      OP_SHL:  op_ctrl = 4'b1010;
      OP_SHR:  op_ctrl = 4'b1000;
      OP_ADD:  op_ctrl = 4'b1100;
      OP_SUB:  op_ctrl = 4'b1101;
      default: op_ctrl = 4'b0000;
    endcase
  endfunction

  state_t     state, state_nxt;

  // captured command: only the operand bits the passes actually need
  logic [2:0] op_q;
  logic [3:0] a_hi_q;
  logic       a3_q;
  logic       a0_q;
  logic [3:0] b_hi_q;

  logic [7:0] r_q;
  logic       c_lo, c_hi, c_fix;

  logic       cmd_illegal;
  logic       need_fix;
  logic [3:0] hi_nib;

  logic [3:0] alu_a_nxt, alu_b_nxt, alu_ctrl_nxt;

  assign cmd_illegal = cmd_op[2] & cmd_op[1];

  // a lo-nibble carry (ADD) or borrow (SUB) must be rippled into the hi nibble
  assign need_fix = ((op_q == OP_ADD) &&  c_lo) ||
                    ((op_q == OP_SUB) && !c_lo);

  // SHL: bit 4 comes from A[3], which the hi-nibble shift cannot see
  assign hi_nib = (op_q == OP_SHL) ? {alu_s[3:1], a3_q} : alu_s;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = cmd_illegal ? RESP : LO;
      LO:   state_nxt = HI;
      HI:   state_nxt = need_fix ? FIX : RESP;
      FIX:  state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // ALU drive is computed for the state being entered so that the registered
  // alu_* outputs are already valid for the whole pass cycle.
  always_comb begin
    cmd_ready    = (state == IDLE);
    rsp_valid    = (state == RESP);
    alu_a_nxt    = 4'h0;
    alu_b_nxt    = 4'h0;
    alu_ctrl_nxt = 4'h0;
    case (state_nxt)
      LO: begin
        alu_a_nxt    = cmd_a[3:0];
        alu_b_nxt    = cmd_b[3:0];
        alu_ctrl_nxt = op_ctrl(cmd_op);
      end
      HI: begin
        alu_a_nxt    = a_hi_q;
        alu_b_nxt    = b_hi_q;
        alu_ctrl_nxt = op_ctrl(op_q);
      end
      FIX: begin
        // the hi result being latched this edge is the FIX operand
        alu_a_nxt    = alu_s;
        alu_b_nxt    = 4'b0001;
        alu_ctrl_nxt = op_ctrl(op_q);
      end
      default: ;
    endcase
  end

  // response fields depend only on registered state, so they hold in RESP
  assign rsp_result = r_q;
  assign rsp_err    = op_q[2] & op_q[1];

  always_comb begin
    case (op_q)
      OP_ADD:  rsp_carry = c_hi | c_fix;
      OP_SUB:  rsp_carry = c_hi & c_fix;
      OP_SHL:  rsp_carry = a_hi_q[3];
      OP_SHR:  rsp_carry = a0_q;
      default: rsp_carry = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= 3'b000;
      a_hi_q         <= 4'h0;
      a3_q           <= 1'b0;
      a0_q           <= 1'b0;
      b_hi_q         <= 4'h0;
      r_q            <= 8'h00;
      c_lo           <= 1'b0;
      c_hi           <= 1'b0;
      c_fix          <= 1'b0;
      alu_a          <= 4'h0;
      alu_b          <= 4'h0;
      alu_sel1       <= 1'b0;
      alu_sel0       <= 1'b0;
      alu_mode_shift <= 1'b0;
      alu_mode_adder <= 1'b0;
    end else begin
      alu_a <= alu_a_nxt;
      alu_b <= alu_b_nxt;
      {alu_sel1, alu_sel0, alu_mode_shift, alu_mode_adder} <= alu_ctrl_nxt;
      case (state)
        IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          a_hi_q <= cmd_a[7:4];
          a3_q   <= cmd_a[3];
          a0_q   <= cmd_a[0];
          b_hi_q <= cmd_b[7:4];
          r_q    <= 8'h00;
          c_lo   <= 1'b0;
          c_hi   <= 1'b0;
          // SUB treats a skipped fix-up as "no borrow"; ADD as "no carry"
          c_fix  <= (cmd_op == OP_SUB);
        end
        LO: begin
          // SHR: bit 3 comes from A[4], which the lo-nibble shift cannot see
          r_q[3:0] <= (op_q == OP_SHR) ? {a_hi_q[0], alu_s[2:0]} : alu_s;
          c_lo     <= alu_carry;
        end
        HI: begin
          r_q[7:4] <= hi_nib;
          c_hi     <= alu_carry;
        end
        FIX: begin
          r_q[7:4] <= alu_s;
          c_fix    <= alu_carry;
        end
        default: ;
      endcase
    end
  end

endmodule
